// File: rtl/trap_pipeline_controller_pkg.sv
// Shared definitions for the pipeline trap controller.
// Holds the synchronous exception cause codes, the machine interrupt cause
// codes and the trap FSM state encoding.
package trap_pipeline_controller_pkg;

    // Synchronous exception cause codes (mcause values, interrupt bit clear)
    localparam int EXCEP_INSTR_MISALIGN = 0;
    localparam int EXCEP_INSTR_FAULT    = 1;
    localparam int EXCEP_ILLEGAL_INSTR  = 2;
    localparam int EXCEP_BREAKPOINT     = 3;
    localparam int EXCEP_LOAD_MISALIGN  = 4;
    localparam int EXCEP_LOAD_FAULT     = 5;
    localparam int EXCEP_STORE_MISALIGN = 6;
    localparam int EXCEP_STORE_FAULT    = 7;
    localparam int EXCEP_ECALL_M        = 11;

    // Machine interrupt cause codes
    localparam int IRQ_CAUSE_SW    = 3;
    localparam int IRQ_CAUSE_TIMER = 7;
    localparam int IRQ_CAUSE_EXT   = 11;

    // Bit positions inside irq_i / irq_mask_i ({external, timer, software})
    localparam int IRQ_BIT_SW    = 0;
    localparam int IRQ_BIT_TIMER = 1;
    localparam int IRQ_BIT_EXT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRAP     = 2'd1,
        ST_REDIRECT = 2'd2
    } trap_state_e;

endpackage

// File: rtl/trap_pipeline_controller_oldest_valid_sel.sv
// Highest-index priority encoder.
// Ports:
//   req_i     in  N      request vector
//   onehot_o  out N      one-hot of the highest set request (0 if none)
//   idx_o     out IDX_W  index of the highest set request (0 if none)
//   any_o     out 1      at least one request set
module oldest_valid_sel #(
    parameter int N     = 5,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        any_o    = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        // Ascending scan: the last hit is the highest index.
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                any_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
        if (any_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/trap_pipeline_controller.sv
// Pipeline hazard and trap controller.
// Produces per-stage stall/flush vectors, arbitrates exceptions (oldest
// stage wins) against masked machine interrupts and runs the trap
// handshake with the CSR unit (IDLE -> TRAP -> REDIRECT -> IDLE).
// Ports:
//   stall_req_i / exc_valid_i / exc_*_i   per-stage requests (top bit ignored)
//   flush_branch_i                        misprediction in BRANCH_STAGE
//   irq_i, irq_mask_i, irq_global_en_i    machine interrupt lines and enables
//   irq_pc_i                              epc used for interrupts
//   trap_ready_i                          CSR unit accepts the trap
//   stall_o, flush_o                      combinational per-stage control
//   trap_*_o                              registered trap record
//   redirect_o                            one-cycle fetch redirect pulse
module trap_pipeline_controller
    import trap_pipeline_controller_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int XLEN         = 32,
    parameter int CAUSE_W      = 4,
    parameter int BRANCH_STAGE = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_STAGES-1:0]         stall_req_i,
    input  logic                          flush_branch_i,
    input  logic [NUM_STAGES-1:0]         exc_valid_i,
    input  logic [NUM_STAGES*CAUSE_W-1:0] exc_cause_i,
    input  logic [NUM_STAGES*XLEN-1:0]    exc_pc_i,
    input  logic [NUM_STAGES*XLEN-1:0]    exc_tval_i,
    input  logic [2:0]                    irq_i,
    input  logic [2:0]                    irq_mask_i,
    input  logic                          irq_global_en_i,
    input  logic [XLEN-1:0]               irq_pc_i,
    input  logic                          trap_ready_i,
    output logic [NUM_STAGES-1:0]         stall_o,
    output logic [NUM_STAGES-1:0]         flush_o,
    output logic                          trap_valid_o,
    output logic                          trap_is_irq_o,
    output logic [CAUSE_W-1:0]            trap_cause_o,
    output logic [XLEN-1:0]               trap_epc_o,
    output logic [XLEN-1:0]               trap_tval_o,
    output logic                          redirect_o
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    // Stages 0..NUM_STAGES-2; writeback never stalls, flushes or traps here.
    localparam logic [NUM_STAGES-1:0] LAST_MASK  = {1'b0, {(NUM_STAGES-1){1'b1}}};
    localparam logic [NUM_STAGES-1:0] BR_MASK    = NUM_STAGES'((1 << BRANCH_STAGE) - 1);
    localparam logic [NUM_STAGES-1:0] TRAP_STALL = LAST_MASK & ~NUM_STAGES'(1);

    trap_state_e          state_q, state_d;
    logic                 is_irq_q, is_irq_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]      epc_q, epc_d;
    logic [XLEN-1:0]      tval_q, tval_d;

    logic [NUM_STAGES-1:0] stall_req_m;
    logic [NUM_STAGES-1:0] stall_base;
    logic [NUM_STAGES-1:0] exc_req;
    logic [NUM_STAGES-1:0] exc_onehot;
    logic [NUM_STAGES-1:0] exc_thermo;
    logic [IDX_W-1:0]      exc_idx;
    logic                  exc_any;
    logic                  exc_accept;
    logic [2:0]            irq_pend;
    logic                  irq_take;
    logic [CAUSE_W-1:0]    irq_cause;

    assign stall_req_m = stall_req_i & LAST_MASK;
    assign exc_req     = exc_valid_i & LAST_MASK;

    oldest_valid_sel #(
        .N     (NUM_STAGES),
        .IDX_W (IDX_W)
    ) u_exc_sel (
        .req_i    (exc_req),
        .onehot_o (exc_onehot),
        .idx_o    (exc_idx),
        .any_o    (exc_any)
    );

    // Stage i stalls whenever it or any older non-writeback stage asks.
    always_comb begin
        stall_base = '0;
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            stall_base[i] = stall_base[i+1] | stall_req_m[i];
        end
    end

    // Bits 0..k set for the winning stage k.
    assign exc_thermo = exc_onehot | (exc_onehot - NUM_STAGES'(1));

    // An exception waits while an older stage is stalled, and is dropped
    // when it sits on the wrong path of a misprediction.
    assign exc_accept = (state_q == ST_IDLE) && exc_any
                        && ((stall_req_m & ~exc_thermo) == '0)
                        && !(flush_branch_i && ((exc_onehot & BR_MASK) != '0));

    assign irq_pend = irq_i & irq_mask_i & {3{irq_global_en_i}};
    assign irq_take = (state_q == ST_IDLE) && (irq_pend != 3'b000)
                      && !exc_accept && (stall_base == '0);

    always_comb begin
        if (irq_pend[IRQ_BIT_EXT]) begin
            irq_cause = CAUSE_W'(IRQ_CAUSE_EXT);
        end else if (irq_pend[IRQ_BIT_SW]) begin
            irq_cause = CAUSE_W'(IRQ_CAUSE_SW);
        end else begin
            irq_cause = CAUSE_W'(IRQ_CAUSE_TIMER);
        end
    end

    always_comb begin
        state_d  = state_q;
        is_irq_d = is_irq_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        tval_d   = tval_q;
        stall_o  = stall_base;
        flush_o  = '0;
        case (state_q)
            ST_IDLE: begin
                if (exc_accept) begin
                    flush_o  = exc_thermo;
                    is_irq_d = 1'b0;
                    cause_d  = exc_cause_i[exc_idx*CAUSE_W +: CAUSE_W];
                    epc_d    = exc_pc_i[exc_idx*XLEN +: XLEN];
                    tval_d   = exc_tval_i[exc_idx*XLEN +: XLEN];
                    state_d  = ST_TRAP;
                end else if (irq_take) begin
                    flush_o  = LAST_MASK;
                    is_irq_d = 1'b1;
                    cause_d  = irq_cause;
                    epc_d    = irq_pc_i;
                    tval_d   = '0;
                    state_d  = ST_TRAP;
                end else if (flush_branch_i) begin
                    flush_o = BR_MASK;
                end
            end
            ST_TRAP: begin
                // Freeze the pipeline and keep fetch empty until the CSR
                // unit takes the trap.
                stall_o    = stall_base | TRAP_STALL;
                flush_o[0] = 1'b1;
                if (trap_ready_i) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (flush_branch_i) begin
                    flush_o = BR_MASK;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            is_irq_q <= 1'b0;
            cause_q  <= '0;
            epc_q    <= '0;
            tval_q   <= '0;
        end else begin
            state_q  <= state_d;
            is_irq_q <= is_irq_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            tval_q   <= tval_d;
        end
    end

    assign trap_valid_o  = (state_q == ST_TRAP);
    assign redirect_o    = (state_q == ST_REDIRECT);
    assign trap_is_irq_o = is_irq_q;
    assign trap_cause_o  = cause_q;
    assign trap_epc_o    = epc_q;
    assign trap_tval_o   = tval_q;

endmodule

// File: tb/tb_trap_pipeline_controller.sv
// Directed testbench for trap_pipeline_controller (NUM_STAGES=5, BRANCH_STAGE=2).
module tb_trap_pipeline_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  stall_req;
    logic        flush_branch;
    logic [4:0]  exc_valid;
    logic [19:0] exc_cause;
    logic [159:0] exc_pc;
    logic [159:0] exc_tval;
    logic [2:0]  irq;
    logic [2:0]  irq_mask;
    logic        irq_gen;
    logic [31:0] irq_pc;
    logic        trap_ready;
    logic [4:0]  stall_o;
    logic [4:0]  flush_o;
    logic        trap_valid_o;
    logic        trap_is_irq_o;
    logic [3:0]  trap_cause_o;
    logic [31:0] trap_epc_o;
    logic [31:0] trap_tval_o;
    logic        redirect_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    trap_pipeline_controller #(
        .NUM_STAGES   (5),
        .XLEN         (32),
        .CAUSE_W      (4),
        .BRANCH_STAGE (2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_req_i     (stall_req),
        .flush_branch_i  (flush_branch),
        .exc_valid_i     (exc_valid),
        .exc_cause_i     (exc_cause),
        .exc_pc_i        (exc_pc),
        .exc_tval_i      (exc_tval),
        .irq_i           (irq),
        .irq_mask_i      (irq_mask),
        .irq_global_en_i (irq_gen),
        .irq_pc_i        (irq_pc),
        .trap_ready_i    (trap_ready),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .trap_valid_o    (trap_valid_o),
        .trap_is_irq_o   (trap_is_irq_o),
        .trap_cause_o    (trap_cause_o),
        .trap_epc_o      (trap_epc_o),
        .trap_tval_o     (trap_tval_o),
        .redirect_o      (redirect_o)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_req    = '0;
        flush_branch = 1'b0;
        exc_valid    = '0;
        exc_cause    = '0;
        exc_pc       = '0;
        exc_tval     = '0;
        irq          = '0;
        irq_mask     = '0;
        irq_gen      = 1'b0;
        irq_pc       = '0;
        trap_ready   = 1'b0;
    endtask

    task automatic set_stage(input int s, input logic [3:0] c, input logic [31:0] pc,
                             input logic [31:0] tv);
        exc_cause[s*4 +: 4] = c;
        exc_pc[s*32 +: 32]  = pc;
        exc_tval[s*32 +: 32] = tv;
    endtask

    // Release a pending trap and wait (bounded) for the redirect pulse.
    task automatic finish_trap(input string tag);
        int waited;
        waited = 0;
        trap_ready = 1'b1;
        step();
        while (!redirect_o && waited < 10) begin
            step();
            waited++;
        end
        trap_ready = 1'b0;
        n_cmp++; if (redirect_o !== 1'b1) begin n_fail++; $display("FAIL %s_redirect got %b want 1", tag, redirect_o); end
        step();
        n_cmp++; if (redirect_o !== 1'b0 || trap_valid_o !== 1'b0) begin n_fail++; $display("FAIL %s_idle redirect=%b valid=%b want 0/0", tag, redirect_o, trap_valid_o); end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #12;
        n_cmp++; if (trap_valid_o !== 1'b0 || redirect_o !== 1'b0 || trap_is_irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl valid=%b redir=%b irq=%b want 0", trap_valid_o, redirect_o, trap_is_irq_o); end
        n_cmp++; if (trap_cause_o !== 4'd0 || trap_epc_o !== 32'd0 || trap_tval_o !== 32'd0) begin n_fail++; $display("FAIL reset_fields cause=%h epc=%h tval=%h want 0", trap_cause_o, trap_epc_o, trap_tval_o); end
        n_cmp++; if (stall_o !== 5'b0 || flush_o !== 5'b0) begin n_fail++; $display("FAIL reset_sf stall=%b flush=%b want 0", stall_o, flush_o); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_exception();
        set_stage(1, 4'd2, 32'h40, 32'h0BAD);
        set_stage(3, 4'd4, 32'h80, 32'h1003);
        exc_valid = 5'b01010;
        #1;
        n_cmp++; if (flush_o !== 5'b01111) begin n_fail++; $display("FAIL exc_flush got %b want 01111", flush_o); end
        n_cmp++; if (trap_valid_o !== 1'b0) begin n_fail++; $display("FAIL exc_valid_early got %b want 0", trap_valid_o); end
        step();
        exc_valid = '0;
        n_cmp++; if (trap_valid_o !== 1'b1 || trap_is_irq_o !== 1'b0) begin n_fail++; $display("FAIL exc_trap valid=%b irq=%b want 1/0", trap_valid_o, trap_is_irq_o); end
        n_cmp++; if (trap_cause_o !== 4'd4 || trap_epc_o !== 32'h80 || trap_tval_o !== 32'h1003) begin n_fail++; $display("FAIL exc_fields cause=%h epc=%h tval=%h want 4/80/1003", trap_cause_o, trap_epc_o, trap_tval_o); end
        // Minimum latency: ready already high gives redirect one cycle later.
        trap_ready = 1'b1;
        step();
        trap_ready = 1'b0;
        n_cmp++; if (redirect_o !== 1'b1 || trap_valid_o !== 1'b0) begin n_fail++; $display("FAIL exc_lat redirect=%b valid=%b want 1/0", redirect_o, trap_valid_o); end
        step();
        n_cmp++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL exc_pulse redirect=%b want 0", redirect_o); end
        clear_inputs();
    endtask

    task automatic test_stall();
        stall_req = 5'b00100; #1;
        n_cmp++; if (stall_o !== 5'b00111) begin n_fail++; $display("FAIL stall_a got %b want 00111", stall_o); end
        stall_req = 5'b01001; #1;
        n_cmp++; if (stall_o !== 5'b01111) begin n_fail++; $display("FAIL stall_b got %b want 01111", stall_o); end
        stall_req = 5'b10000; #1;
        n_cmp++; if (stall_o !== 5'b00000) begin n_fail++; $display("FAIL stall_c got %b want 00000", stall_o); end
        // Exception in stage 1 blocked by an older stall in stage 2.
        stall_req = 5'b00100;
        exc_valid = 5'b00010;
        set_stage(1, 4'd2, 32'h44, 32'h0);
        #1;
        n_cmp++; if (flush_o !== 5'b00000) begin n_fail++; $display("FAIL stall_block_flush got %b want 00000", flush_o); end
        step();
        n_cmp++; if (trap_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_block_trap got %b want 0", trap_valid_o); end
        clear_inputs();
        #1;
    endtask

    task automatic test_branch();
        flush_branch = 1'b1;
        exc_valid    = 5'b00010;
        set_stage(1, 4'd2, 32'h44, 32'h0);
        #1;
        n_cmp++; if (flush_o !== 5'b00011) begin n_fail++; $display("FAIL br_drop_flush got %b want 00011", flush_o); end
        step();
        clear_inputs();
        n_cmp++; if (trap_valid_o !== 1'b0) begin n_fail++; $display("FAIL br_drop_trap got %b want 0", trap_valid_o); end
        flush_branch = 1'b1;
        exc_valid    = 5'b01000;
        set_stage(3, 4'd6, 32'h120, 32'h2222);
        #1;
        n_cmp++; if (flush_o !== 5'b01111) begin n_fail++; $display("FAIL br_exc_flush got %b want 01111", flush_o); end
        step();
        clear_inputs();
        n_cmp++; if (trap_valid_o !== 1'b1 || trap_cause_o !== 4'd6 || trap_epc_o !== 32'h120) begin n_fail++; $display("FAIL br_exc_trap valid=%b cause=%h epc=%h want 1/6/120", trap_valid_o, trap_cause_o, trap_epc_o); end
        finish_trap("br");
    endtask

    task automatic test_irq();
        irq = 3'b010; irq_mask = 3'b111; irq_gen = 1'b1; irq_pc = 32'h200;
        #1;
        n_cmp++; if (flush_o !== 5'b01111) begin n_fail++; $display("FAIL irq_flush got %b want 01111", flush_o); end
        step();
        irq = 3'b000;
        n_cmp++; if (trap_valid_o !== 1'b1 || trap_is_irq_o !== 1'b1 || trap_cause_o !== 4'd7) begin n_fail++; $display("FAIL irq_timer valid=%b irq=%b cause=%h want 1/1/7", trap_valid_o, trap_is_irq_o, trap_cause_o); end
        n_cmp++; if (trap_epc_o !== 32'h200 || trap_tval_o !== 32'h0) begin n_fail++; $display("FAIL irq_fields epc=%h tval=%h want 200/0", trap_epc_o, trap_tval_o); end
        finish_trap("irq_t");
        // Masked / globally disabled lines are not taken.
        irq = 3'b010; irq_mask = 3'b101; #1;
        n_cmp++; if (flush_o !== 5'b00000) begin n_fail++; $display("FAIL irq_masked flush=%b want 00000", flush_o); end
        irq_mask = 3'b111; irq_gen = 1'b0; #1;
        n_cmp++; if (flush_o !== 5'b00000) begin n_fail++; $display("FAIL irq_gdis flush=%b want 00000", flush_o); end
        // Stall pending blocks interrupt entry.
        irq_gen = 1'b1; stall_req = 5'b00001; #1;
        n_cmp++; if (flush_o !== 5'b00000) begin n_fail++; $display("FAIL irq_stall flush=%b want 00000", flush_o); end
        stall_req = '0;
        // Priority: external over all, software over timer.
        irq = 3'b111;
        step();
        irq = 3'b000;
        n_cmp++; if (trap_cause_o !== 4'd11 || trap_is_irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_ext cause=%h irq=%b want b/1", trap_cause_o, trap_is_irq_o); end
        finish_trap("irq_e");
        irq = 3'b011;
        step();
        irq = 3'b000;
        n_cmp++; if (trap_cause_o !== 4'd3) begin n_fail++; $display("FAIL irq_sw cause=%h want 3", trap_cause_o); end
        finish_trap("irq_s");
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        irq = 3'b010; irq_mask = 3'b111; irq_gen = 1'b1; irq_pc = 32'h300;
        exc_valid = 5'b01000;
        set_stage(3, 4'd5, 32'h90, 32'h4444);
        step();
        exc_valid = '0;
        n_cmp++; if (trap_is_irq_o !== 1'b0 || trap_cause_o !== 4'd5 || trap_epc_o !== 32'h90) begin n_fail++; $display("FAIL b2b_exc irq=%b cause=%h epc=%h want 0/5/90", trap_is_irq_o, trap_cause_o, trap_epc_o); end
        trap_ready = 1'b1;
        step();
        trap_ready = 1'b0;
        n_cmp++; if (redirect_o !== 1'b1 || flush_o !== 5'b00000) begin n_fail++; $display("FAIL b2b_redir redirect=%b flush=%b want 1/00000", redirect_o, flush_o); end
        step();
        // Back in IDLE with the interrupt still held: taken now.
        n_cmp++; if (flush_o !== 5'b01111) begin n_fail++; $display("FAIL b2b_irq_flush got %b want 01111", flush_o); end
        step();
        irq = 3'b000;
        n_cmp++; if (trap_valid_o !== 1'b1 || trap_is_irq_o !== 1'b1 || trap_cause_o !== 4'd7 || trap_epc_o !== 32'h300) begin n_fail++; $display("FAIL b2b_irq valid=%b irq=%b cause=%h epc=%h want 1/1/7/300", trap_valid_o, trap_is_irq_o, trap_cause_o, trap_epc_o); end
        finish_trap("b2b");
        clear_inputs();
    endtask

    task automatic test_trap_hold();
        exc_valid = 5'b00100;
        set_stage(2, 4'd11, 32'hA0, 32'h77);
        step();
        exc_valid = '0;
        for (int c = 0; c < 3; c++) begin
            // Distractors that must be ignored while the trap is pending.
            exc_valid    = (c == 0) ? 5'b01000 : 5'b00000;
            flush_branch = (c == 1);
            irq          = (c == 2) ? 3'b100 : 3'b000;
            irq_mask     = 3'b111;
            irq_gen      = 1'b1;
            set_stage(3, 4'd1, 32'hDEAD, 32'hBEEF);
            #1;
            n_cmp++; if (trap_valid_o !== 1'b1 || trap_cause_o !== 4'd11 || trap_epc_o !== 32'hA0 || trap_tval_o !== 32'h77) begin n_fail++; $display("FAIL hold_fields[%0d] valid=%b cause=%h epc=%h tval=%h", c, trap_valid_o, trap_cause_o, trap_epc_o, trap_tval_o); end
            n_cmp++; if (stall_o !== 5'b01110 || flush_o !== 5'b00001) begin n_fail++; $display("FAIL hold_sf[%0d] stall=%b flush=%b want 01110/00001", c, stall_o, flush_o); end
            step();
        end
        clear_inputs();
        finish_trap("hold");
    endtask

    task automatic test_reset_mid_trap();
        exc_valid = 5'b01000;
        set_stage(3, 4'd7, 32'hC0, 32'h55);
        step();
        exc_valid = '0;
        n_cmp++; if (trap_valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre valid=%b want 1", trap_valid_o); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (trap_valid_o !== 1'b0 || trap_cause_o !== 4'd0 || trap_epc_o !== 32'd0 || trap_tval_o !== 32'd0 || trap_is_irq_o !== 1'b0 || redirect_o !== 1'b0) begin n_fail++; $display("FAIL rst_async valid=%b cause=%h epc=%h tval=%h", trap_valid_o, trap_cause_o, trap_epc_o, trap_tval_o); end
        #1 rst = 1'b0;
        step();
        n_cmp++; if (trap_valid_o !== 1'b0 || stall_o !== 5'b0 || flush_o !== 5'b0) begin n_fail++; $display("FAIL rst_idle valid=%b stall=%b flush=%b", trap_valid_o, stall_o, flush_o); end
        exc_valid = 5'b00001;
        set_stage(0, 4'd1, 32'h10, 32'h10);
        #1;
        n_cmp++; if (flush_o !== 5'b00001) begin n_fail++; $display("FAIL rst_accept flush=%b want 00001", flush_o); end
        step();
        exc_valid = '0;
        n_cmp++; if (trap_valid_o !== 1'b1 || trap_cause_o !== 4'd1) begin n_fail++; $display("FAIL rst_trap valid=%b cause=%h want 1/1", trap_valid_o, trap_cause_o); end
        finish_trap("rst");
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_stall();
        test_branch();
        test_irq();
        test_back_to_back();
        test_trap_hold();
        test_reset_mid_trap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/trap_pipeline_controller.md
# trap_pipeline_controller

Parametrised pipeline hazard and trap controller for the N-stage core. It generates per-stage stall and flush vectors from stage stall requests and branch mispredictions. It arbitrates synchronous exceptions from any stage and masked machine interrupts, then runs a trap handshake with the CSR unit. It replaces the fixed 5-stage combinational controller, adding interrupt handling, a CSR handshake and generic depth.

## Interface
Parameters:
- NUM_STAGES, 5, pipeline depth. Stage 0 is fetch; stage NUM_STAGES-1 is writeback.
- XLEN, 32, PC and address width.
- CAUSE_W, 4, trap cause width.
- BRANCH_STAGE, 2, stage that resolves branches. Range 1..NUM_STAGES-2.

Ports (reset is asynchronous, active-high; one clock):
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous active-high reset.
- stall_req_i  in  NUM_STAGES  per-stage stall request. Bit NUM_STAGES-1 is ignored.
- flush_branch_i  in  1  misprediction detected in BRANCH_STAGE.
- exc_valid_i  in  NUM_STAGES  per-stage exception. Bit NUM_STAGES-1 is ignored.
- exc_cause_i  in  NUM_STAGES*CAUSE_W  per-stage cause, flattened; stage i occupies slice i.
- exc_pc_i  in  NUM_STAGES*XLEN  per-stage PC, flattened.
- exc_tval_i  in  NUM_STAGES*XLEN  per-stage faulting address, flattened.
- irq_i  in  3  {external, timer, software} machine interrupt lines.
- irq_mask_i  in  3  mie enable bits, same order as irq_i.
- irq_global_en_i  in  1  mstatus.MIE.
- irq_pc_i  in  XLEN  PC of the oldest uncommitted instruction.
- trap_ready_i  in  1  CSR unit accepts the trap.
- stall_o  out  NUM_STAGES  hold stage i.
- flush_o  out  NUM_STAGES  kill the instruction in stage i.
- trap_valid_o  out  1  trap presented to the CSR unit.
- trap_is_irq_o  out  1  trap is an interrupt.
- trap_cause_o  out  CAUSE_W  trap cause.
- trap_epc_o  out  XLEN  PC written to mepc.
- trap_tval_o  out  XLEN  value written to mtval.
- redirect_o  out  1  one-cycle pulse; fetch loads the trap vector.

## Operation
- Stall: stall_o[i] = OR of stall_req_i[j] for i ≤ j ≤ NUM_STAGES-2. stall_o[NUM_STAGES-1] is always 0.
- Exception arbitration: the oldest stage wins, i.e. the highest index k with exc_valid_i[k]=1.
  - Accept only in IDLE and only when no stall_req_i[j] is set for j > k. Otherwise the exception waits; the source stage holds it.
- Exception acceptance:
  - flush_o[0..k]=1 in the same cycle.
  - Capture cause, pc and tval of stage k into registers.
  - Go to TRAP.
- Misprediction: flush_o[0..BRANCH_STAGE-1]=1.
  - An exception with k < BRANCH_STAGE in the same cycle is on the wrong path and is dropped.
  - An exception with k ≥ BRANCH_STAGE takes precedence; the misprediction flush is subsumed.
- Interrupts:
  - pend = irq_i & irq_mask_i, gated by irq_global_en_i. Evaluated every cycle; this block does not latch it. Sources hold their lines until serviced.
  - Taken in IDLE only, when no exception is accepted that cycle and stall_o is all zero.
  - Priority: external (cause 11) > software (3) > timer (7).
  - On take: flush_o[0..NUM_STAGES-2]=1, epc=irq_pc_i, tval=0, is_irq=1, go to TRAP.
- FSM:
  - IDLE: no trap in progress.
  - TRAP:
    - trap_valid_o=1 with the registered fields, held stable.
    - stall_o[1..NUM_STAGES-2]=1 and flush_o[0]=1.
    - New exceptions, interrupts and mispredictions are ignored.
    - On trap_ready_i=1, go to REDIRECT.
  - REDIRECT: redirect_o=1 for exactly one cycle, then IDLE.
- Reset values:
  - State IDLE.
  - trap_valid_o, trap_is_irq_o, trap_cause_o, trap_epc_o, trap_tval_o and redirect_o all 0.
  - Reset mid-TRAP drops the trap.

## Timing
- stall_o and flush_o are combinational from inputs and state, valid in the same cycle.
- Trap outputs are registered. trap_valid_o rises one cycle after acceptance.
- Minimum acceptance-to-redirect latency is 2 cycles (trap_ready_i already high), and redirect_o rises in the cycle after trap_ready_i is sampled high.
- A back-to-back trap is possible from the cycle after REDIRECT.

## Structure
- The shared package (extending operations.vh) holds:
  - EXCEP_* cause codes.
  - IRQ cause codes 3, 7 and 11.
  - FSM state encodings.
- Sub-module oldest_valid_sel: parametrised highest-index one-hot/index priority encoder over NUM_STAGES, reused for exception arbitration.

## Test plan
NUM_STAGES=5, BRANCH_STAGE=2 throughout.
1. exc_valid_i=5'b01010; stage 3 cause 4, pc 0x80, tval 0x1003 -> flush_o=5'b01111. Next cycle trap_valid_o=1, cause 4, epc 0x80, tval 0x1003.
2. stall_req_i=5'b00100 -> stall_o=5'b00111. stall_req_i=5'b01001 -> stall_o=5'b01111. stall_req_i=5'b10000 -> stall_o=0.
3. flush_branch_i=1 with exc_valid_i=5'b00010 -> flush_o=5'b00011, no trap. With exc_valid_i=5'b01000 -> flush_o=5'b01111 and a trap.
4. irq_i=3'b010 (timer), mask 3'b111, global en 1, irq_pc_i=0x200, pipeline idle -> flush_o=5'b01111, then trap cause 7, is_irq 1, epc 0x200. If an exception arrives in the same cycle, the exception traps first and the interrupt traps after REDIRECT.
5. TRAP with trap_ready_i low for 3 cycles -> trap_valid_o high with stable fields, stall_o=5'b01110, flush_o[0]=1. On ready: one redirect_o pulse, then IDLE.
6. rst_i asserted mid-TRAP -> all trap outputs 0 immediately. After release, the FSM is in IDLE.
